// File: rtl/eq_checker_pkg.sv
// eq_checker_pkg: shared state encoding and defaults for the NAND equivalence checker
package eq_checker_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
    localparam int         NVEC_DEFAULT = 4;
    localparam logic [2:0] CNT_MAX      = 3'd7;
endpackage

// File: rtl/sat_cnt3.sv
// sat_cnt3: 3-bit up counter with synchronous clear that holds at its maximum
module sat_cnt3
    import eq_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] q
);
    logic [2:0] q_d, q_q;
    // clear wins over increment; increment stops at the maximum instead of wrapping
    always_comb q_d = clr ? 3'd0 : (inc && q_q != CNT_MAX) ? q_q + 3'd1 : q_q;
    // count register
    always_ff @(posedge clk) begin
        if (reset) q_q <= 3'd0;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/eq_checker.sv
// eq_checker: compares two NAND implementations against a golden NAND over a run of NVEC vectors
module eq_checker
    import eq_checker_pkg::*;
#(
    parameter int NVEC = NVEC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       valid,
    input  logic       x,
    input  logic       y,
    input  logic       a,
    input  logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] vec_cnt,
    output logic [2:0] err_cnt,
    output logic       first_x,
    output logic       first_y,
    output logic       first_vld
);
    state_e     state_q, state_d;
    logic [2:0] vec_cnt_q, vec_cnt_d;
    logic       first_x_q, first_x_d;
    logic       first_y_q, first_y_d;
    logic       first_vld_q, first_vld_d;
    logic       golden, vec_err, accept, clr, last;
    // vector qualification: golden NAND, error detect, run start and final vector
    always_comb begin
        golden  = ~(x & y);
        vec_err = (a != b) || (a != golden) || (b != golden);
        accept  = (state_q == RUN) && valid;
        clr     = (state_q != RUN) && start;
        last    = accept && (vec_cnt_q + 3'd1 == 3'(NVEC));
    end
    // next state, vector count and first-error capture; the capture keeps its old x/y on a new run
    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        first_x_d   = first_x_q;
        first_y_d   = first_y_q;
        first_vld_d = first_vld_q;
        if (clr) begin
            state_d     = RUN;
            vec_cnt_d   = 3'd0;
            first_vld_d = 1'b0;
        end else if (accept) begin
            vec_cnt_d = vec_cnt_q + 3'd1;
            if (vec_err && !first_vld_q) begin
                first_x_d   = x;
                first_y_d   = y;
                first_vld_d = 1'b1;
            end
            if (last) state_d = DONE;
        end
    end
    // state and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_cnt_q   <= 3'd0;
            first_x_q   <= 1'b0;
            first_y_q   <= 1'b0;
            first_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            first_x_q   <= first_x_d;
            first_y_q   <= first_y_d;
            first_vld_q <= first_vld_d;
        end
    end
    sat_cnt3 u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (accept && vec_err),
        .q     (err_cnt)
    );
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_cnt == 3'd0);
    assign vec_cnt   = vec_cnt_q;
    assign first_x   = first_x_q;
    assign first_y   = first_y_q;
    assign first_vld = first_vld_q;
endmodule

// File: tb/tb_eq_checker.sv
// tb_eq_checker: random and directed runs on NVEC=4 and NVEC=7 checkers against a run-level model
module tb_eq_checker;
    import eq_checker_pkg::*;
    logic clk = 1'b0;
    logic reset, start, valid, x, y, a, b;
    logic       busy_o[2], done_o[2], pass_o[2], fx_o[2], fy_o[2], fvld_o[2];
    logic [2:0] vec_o[2], err_o[2];
    int passed = 0;
    int total  = 0;
    always #5 clk = ~clk;
    eq_checker #(.NVEC(NVEC_DEFAULT)) u4 (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .x(x), .y(y), .a(a), .b(b),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .vec_cnt(vec_o[0]), .err_cnt(err_o[0]),
        .first_x(fx_o[0]), .first_y(fy_o[0]), .first_vld(fvld_o[0])
    );
    eq_checker #(.NVEC(7)) u7 (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .x(x), .y(y), .a(a), .b(b),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .vec_cnt(vec_o[1]), .err_cnt(err_o[1]),
        .first_x(fx_o[1]), .first_y(fy_o[1]), .first_vld(fvld_o[1])
    );
    // run-level model: a run is in progress or finished, with a vector count and an unsaturated error tally
    int nv[2] = '{NVEC_DEFAULT, 7};
    bit m_init = 1'b0;
    bit m_busy[2], m_done[2], m_fvld[2], m_fx[2], m_fy[2];
    int m_vec[2], m_errs[2];
    function automatic bit g(input bit xi, input bit yi);
        return !(xi && yi);
    endfunction
    task automatic model_update();
        bit e;
        e = (a != b) || (a != g(x, y)) || (b != g(x, y));
        if (reset) m_init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_done[k] = 0; m_vec[k] = 0; m_errs[k] = 0;
                m_fvld[k] = 0; m_fx[k] = 0; m_fy[k] = 0;
            end else if (!m_busy[k] && start) begin
                m_busy[k] = 1; m_done[k] = 0; m_vec[k] = 0; m_errs[k] = 0; m_fvld[k] = 0;
            end else if (m_busy[k] && valid) begin
                m_vec[k]++;
                if (e) begin
                    if (!m_fvld[k]) begin
                        m_fvld[k] = 1; m_fx[k] = x; m_fy[k] = y;
                    end
                    m_errs[k]++;
                end
                if (m_vec[k] == nv[k]) begin
                    m_busy[k] = 0; m_done[k] = 1;
                end
            end
        end
    endtask
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    // compare both checkers against the model just after every active edge
    always @(posedge clk) begin
        #1;
        if (m_init) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d busy", k), busy_o[k], m_busy[k]);
                chk($sformatf("u%0d done", k), done_o[k], m_done[k]);
                chk($sformatf("u%0d pass", k), pass_o[k], m_done[k] && m_errs[k] == 0);
                chk($sformatf("u%0d vec_cnt", k), vec_o[k], m_vec[k]);
                chk($sformatf("u%0d err_cnt", k), err_o[k], m_errs[k] > 7 ? 7 : m_errs[k]);
                chk($sformatf("u%0d first_vld", k), fvld_o[k], m_fvld[k]);
                chk($sformatf("u%0d first_x", k), fx_o[k], m_fx[k]);
                chk($sformatf("u%0d first_y", k), fy_o[k], m_fy[k]);
            end
        end
    end
    task automatic step();
        model_update();
        @(negedge clk);
    endtask
    task automatic vec(input bit xi, input bit yi, input bit ai, input bit bi);
        start = 0; valid = 1; x = xi; y = yi; a = ai; b = bi;
        step();
    endtask
    task automatic idle();
        start = 0; valid = 0;
        step();
    endtask
    task automatic start_pulse();
        start = 1; valid = 0;
        step();
        start = 0;
    endtask
    task automatic do_reset();
        reset = 1; start = 1; valid = 1;
        step();
        reset = 0; start = 0; valid = 0;
    endtask
    initial begin
        bit [6:0] pat;
        bit ea, eb, ai;
        reset = 1; start = 0; valid = 0; x = 0; y = 0; a = 0; b = 0;
        @(negedge clk);
        step();
        step();
        reset = 0;
        chk("reset busy", busy_o[0], 0);
        chk("reset done", done_o[0], 0);
        chk("reset pass", pass_o[0], 0);
        chk("reset err_cnt", err_o[0], 0);
        chk("reset first_x", fx_o[0], 0);
        vec(1, 1, 1, 1);
        vec(0, 1, 0, 0);
        chk("idle valid vec_cnt", vec_o[0], 0);
        start_pulse();
        chk("start busy", busy_o[0], 1);
        for (int i = 0; i < 4; i++) vec(i[1], i[0], g(i[1], i[0]), g(i[1], i[0]));
        idle();
        chk("clean done", done_o[0], 1);
        chk("clean pass", pass_o[0], 1);
        chk("clean vec_cnt", vec_o[0], 4);
        chk("clean err_cnt", err_o[0], 0);
        chk("clean first_vld", fvld_o[0], 0);
        chk("u7 still busy", busy_o[1], 1);
        vec(1, 1, 1, 0);
        vec(0, 0, 0, 1);
        chk("done valid vec_cnt", vec_o[0], 4);
        chk("done valid err_cnt", err_o[0], 0);
        do_reset();
        start_pulse();
        for (int i = 0; i < 4; i++) vec(i[1], i[0], (i == 1 || i == 3) ? !g(i[1], i[0]) : g(i[1], i[0]), g(i[1], i[0]));
        idle();
        chk("faulty pass", pass_o[0], 0);
        chk("faulty err_cnt", err_o[0], 2);
        chk("faulty first_x", fx_o[0], 0);
        chk("faulty first_y", fy_o[0], 1);
        chk("faulty first_vld", fvld_o[0], 1);
        do_reset();
        start_pulse();
        for (int i = 0; i < 7; i++) begin
            ai = 1'($urandom);
            vec(1'($urandom), 1'($urandom), ai, !ai);
        end
        idle();
        chk("sat u7 err_cnt", err_o[1], 7);
        chk("sat u7 done", done_o[1], 1);
        chk("sat u7 vec_cnt", vec_o[1], 7);
        chk("sat u4 err_cnt", err_o[0], 4);
        for (int i = 0; i < 3; i++) vec(1, 0, 0, 1);
        chk("sat u7 err_cnt held", err_o[1], 7);
        do_reset();
        start_pulse();
        pat = 7'b1011001;
        for (int j = 0; j < 7; j++) begin
            if (pat[j]) vec(1, 0, 1, 1);
            else idle();
            chk($sformatf("gap done %0d", j), done_o[0], j == 6 ? 1 : 0);
        end
        chk("gap vec_cnt", vec_o[0], 4);
        do_reset();
        start_pulse();
        vec(1, 1, 1, 1);
        vec(0, 0, 1, 1);
        chk("pre-reset first_vld", fvld_o[0], 1);
        chk("pre-reset first_x", fx_o[0], 1);
        x = 1; y = 1; a = 0; b = 1;
        do_reset();
        chk("mid-run reset busy", busy_o[0], 0);
        chk("mid-run reset vec_cnt", vec_o[0], 0);
        chk("mid-run reset first_vld", fvld_o[0], 0);
        chk("mid-run reset first_x", fx_o[0], 0);
        chk("mid-run reset first_y", fy_o[0], 0);
        start_pulse();
        for (int i = 0; i < 4; i++) vec(i[0], i[1], g(i[0], i[1]), g(i[0], i[1]));
        idle();
        chk("post-reset pass", pass_o[0], 1);
        do_reset();
        start_pulse();
        vec(0, 1, 1, 1);
        start = 1; valid = 1; x = 1; y = 1; a = 0; b = 0;
        step();
        start = 0;
        chk("start in run busy", busy_o[0], 1);
        chk("start in run vec_cnt", vec_o[0], 2);
        vec(1, 0, 1, 1);
        vec(0, 0, 1, 1);
        chk("run end done", done_o[0], 1);
        start_pulse();
        chk("restart busy", busy_o[0], 1);
        chk("restart done", done_o[0], 0);
        chk("restart vec_cnt", vec_o[0], 0);
        chk("restart err_cnt", err_o[0], 0);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom % 64) == 0;
            start = ($urandom % 8) == 0;
            valid = 1'($urandom);
            x = 1'($urandom);
            y = 1'($urandom);
            ea = ($urandom % 4) == 0;
            eb = ($urandom % 4) == 0;
            a = g(x, y) ^ ea;
            b = g(x, y) ^ eb;
            step();
        end
        reset = 0; start = 0; valid = 0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
